// File: rtl/toe_tx_interface.sv
// Drains the engine's transmit FIFO, decodes CONNECT/DISCONNECT/MESSAGE records
// and presents them to the TCP offload engine through ready/ack handshakes.
module toe_tx_interface #(
  parameter int HOST_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty_i,
  output logic              fifo_rd_o,
  input  logic [7:0]        fifo_data_i,
  output logic              connect_o,
  output logic              disconnect_o,
  output logic [HOST_W-1:0] cmd_host_o,
  input  logic              cmd_ack_i,
  output logic              tx_valid_o,
  output logic [7:0]        tx_data_o,
  output logic              tx_last_o,
  input  logic              tx_ready_i,
  output logic              msg_sent_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_PAYLOAD,
    S_CMD
  } state_t;

  state_t            state_q, state_d;
  logic              is_disc_q, is_disc_d;
  logic [HOST_W-1:0] host_q, host_d;
  logic [7:0]        remaining_q, remaining_d;
  logic [1:0]        cnt_q, cnt_d, cnt_c;
  logic              rd_pend_q;
  logic [7:0]        sk0_q, sk1_q, sk0_d, sk1_d;
  logic              head_vld;
  logic              consume;
  logic              err;
  logic              tx_valid;
  logic              tx_last;

  always_comb begin
    state_d     = state_q;
    is_disc_d   = is_disc_q;
    host_d      = host_q;
    remaining_d = remaining_q;
    consume     = 1'b0;
    err         = 1'b0;
    head_vld    = (cnt_q != 2'd0);
    tx_valid    = (state_q == S_PAYLOAD) && head_vld;
    tx_last     = tx_valid && (remaining_q == 8'd1);

    case (state_q)
      S_IDLE: begin
        if (head_vld) begin
          consume = 1'b1;
          case (sk0_q)
            8'h01: begin
              state_d   = S_ADDR;
              is_disc_d = 1'b0;
            end
            8'h02: begin
              state_d   = S_ADDR;
              is_disc_d = 1'b1;
            end
            8'h03:   state_d = S_LEN;
            default: err = 1'b1;
          endcase
        end
      end
      S_ADDR: begin
        if (head_vld) begin
          consume = 1'b1;
          host_d  = sk0_q[HOST_W-1:0];
          state_d = S_CMD;
        end
      end
      S_LEN: begin
        if (head_vld) begin
          consume = 1'b1;
          if (sk0_q == 8'd0) begin
            // A zero-length message is a complete (but illegal) record
            err     = 1'b1;
            state_d = S_IDLE;
          end else begin
            remaining_d = sk0_q;
            state_d     = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (tx_valid && tx_ready_i) begin
          consume     = 1'b1;
          remaining_d = remaining_q - 8'd1;
          if (remaining_q == 8'd1) begin
            state_d = S_IDLE;
          end
        end
      end
      S_CMD: begin
        if (cmd_ack_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Skid buffer: head shifts out on consume, returning read data lands behind
  // whatever survives the consume, so entries are never reordered.
  always_comb begin
    cnt_c = cnt_q - {1'b0, consume};
    sk0_d = consume ? sk1_q : sk0_q;
    sk1_d = sk1_q;
    if (rd_pend_q) begin
      if (cnt_c == 2'd0) begin
        sk0_d = fifo_data_i;
      end else begin
        sk1_d = fifo_data_i;
      end
    end
    cnt_d = cnt_c + {1'b0, rd_pend_q};
  end

  assign fifo_rd_o = rst && !fifo_empty_i && (cnt_d < 2'd2);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      is_disc_q   <= 1'b0;
      host_q      <= '0;
      remaining_q <= 8'd0;
      cnt_q       <= 2'd0;
      rd_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_disc_q   <= is_disc_d;
      host_q      <= host_d;
      remaining_q <= remaining_d;
      cnt_q       <= cnt_d;
      rd_pend_q   <= fifo_rd_o;
    end
  end

  always_ff @(posedge clk) begin
    sk0_q <= sk0_d;
    sk1_q <= sk1_d;
  end

  assign connect_o    = (state_q == S_CMD) && !is_disc_q;
  assign disconnect_o = (state_q == S_CMD) && is_disc_q;
  assign cmd_host_o   = host_q;
  assign tx_valid_o   = tx_valid;
  assign tx_data_o    = tx_valid ? sk0_q : 8'd0;
  assign tx_last_o    = tx_last;
  assign msg_sent_o   = tx_last && tx_ready_i;
  assign err_o        = err;

endmodule

// File: doc/toe_tx_interface.md
# toe_tx_interface

Outbound-side controller that drains the engine's 8-bit transmit FIFO (the FIFO written by the fix engine's `fifo_write_o`/`message_o`) and drives the TCP offload engine (TOE). It decodes the FIFO record stream into connect requests, disconnect requests and framed FIX message bursts. It presents these to the TOE with ready/ack handshakes, making it the reader counterpart of the engine's FIFO writer.

## Interface
- `HOST_W`, default 4: host address width, must be ≤ 8; the address byte's low `HOST_W` bits are used.
- `clk`  in  1  rising-edge clock; the only clock in the block.
- `rst`  in  1  reset, synchronous and active-low.
- `fifo_empty_i`  in  1  transmit FIFO empty.
- `fifo_rd_o`  out  1  FIFO read strobe.
- `fifo_data_i`  in  8  FIFO read data, valid the cycle after `fifo_rd_o`.
- `connect_o`  out  1  connect request, held until acked.
- `disconnect_o`  out  1  disconnect request, held until acked.
- `cmd_host_o`  out  HOST_W  host address for connect/disconnect.
- `cmd_ack_i`  in  1  TOE accepts the pending command.
- `tx_valid_o`  out  1  payload byte valid.
- `tx_data_o`  out  8  payload byte.
- `tx_last_o`  out  1  final byte of the message.
- `tx_ready_i`  in  1  TOE accepts the byte.
- `msg_sent_o`  out  1  one-cycle pulse on the accepted last byte.
- `err_o`  out  1  one-cycle pulse on a framing error.

## Operation
- FIFO record format (fixed):
  - `8'h01` followed by a host byte means CONNECT.
  - `8'h02` followed by a host byte means DISCONNECT.
  - `8'h03` followed by a length byte L, then L payload bytes, means MESSAGE.
- Prefetch: a 2-entry skid buffer is loaded from `fifo_data_i` one cycle after each read.
  - `fifo_rd_o = !fifo_empty_i && (skid_count_after_consume + rd_pending) < 2`.
  - The skid buffer never overflows and sustains 1 byte/cycle.
- States: IDLE, ADDR, LEN, PAYLOAD, CMD.
  - IDLE: consumes the head byte.
    - `01` or `02` → ADDR, latching the command kind.
    - `03` → LEN.
    - Any other value → pulse `err_o`, drop the byte, stay IDLE.
  - ADDR: consumes the head byte and loads `cmd_host_o` from byte[HOST_W-1:0]. Raises `connect_o` or `disconnect_o` the next cycle → CMD.
  - CMD: holds the request and address stable, consuming nothing. When `cmd_ack_i` is sampled high:
    - the request drops the next cycle;
    - state → IDLE.
  - LEN: consumes the head byte as `remaining`.
    - L = 0 → pulse `err_o`, return to IDLE (the record is complete).
    - Otherwise → PAYLOAD.
  - PAYLOAD:
    - `tx_valid_o` = skid buffer non-empty; `tx_data_o` = head byte.
    - `tx_last_o` = `tx_valid_o && remaining == 1`.
    - On `tx_valid_o && tx_ready_i`: consume the byte and decrement `remaining`.
    - On the last byte: pulse `msg_sent_o` and go to IDLE.
- Handshake rules:
  - `tx_valid_o` never depends on `tx_ready_i`.
  - Once raised, `tx_valid_o` and `tx_data_o` stay stable until accepted, since skid contents are never reordered.
  - FIFO underrun mid-message deasserts `tx_valid_o` until data arrives. This is not an error.
- `cmd_ack_i` outside CMD and `tx_ready_i` outside PAYLOAD are ignored.
- `remaining` is 8 bits and never wraps: its decrement is gated to PAYLOAD.

## Timing
- Reset (`rst` = 0 at a clock edge) forces:
  - all outputs to 0;
  - `cmd_host_o` to 0;
  - state to IDLE;
  - skid buffer empty, `rd_pending` 0, `remaining` 0.
  - Reset mid-message discards the partially sent record. Any read in flight at reset is discarded: its data is not captured.
- FIFO read latency is 1 cycle. A byte read in cycle n is in the skid buffer at cycle n+2.
- Streaming message, FIFO non-empty from cycle 0, `tx_ready_i` = 1:
  - opcode consumed in cycle 2;
  - length in cycle 3;
  - first `tx_valid_o` in cycle 4;
  - then one byte per cycle;
  - `msg_sent_o` coincides with the last handshake.
- Command, FIFO non-empty from cycle 0:
  - opcode in cycle 2;
  - address in cycle 3;
  - `connect_o`/`disconnect_o` high from cycle 4;
  - with ack in cycle k, the request is low in cycle k+1 and the next opcode is consumed in cycle k+1.
- Back-to-back records: the next opcode is consumed the cycle after the previous record completes. There are no idle gaps when data is buffered.
- At most one skid-buffer consume per cycle. A FIFO read and a consume may occur in the same cycle.

## Test plan
- FIFO holds `03 03 38 3D 46`, `tx_ready_i` = 1 → bytes 38, 3D, 46 on cycles 4–6; `tx_last_o` and `msg_sent_o` high on cycle 6 only.
- FIFO holds `01 05`, `cmd_ack_i` asserted on cycle 8 → `connect_o` = 1 with `cmd_host_o` = 5 from cycle 4 through 8, 0 on cycle 9; `fifo_rd_o` stops once 2 further bytes are buffered.
- 4-byte message with `tx_ready_i` low on cycles 5–7 → `tx_data_o` frozen on byte 2 during the stall; no byte lost or duplicated; total 4 handshakes.
- FIFO holds `7F 03 00 02 0A` → `err_o` pulses twice (bad opcode, zero length); then `disconnect_o` with `cmd_host_o` = 0xA.
- FIFO empties after byte 2 of a 5-byte message, then refills 6 cycles later → `tx_valid_o` low during the gap with no `err_o`; the message completes with a correct `tx_last_o`.
- `rst` = 0 while 3 payload bytes remain → next cycle all outputs 0 and state IDLE; the following FIFO byte is interpreted as an opcode.
